// File: rtl/operand_stack_if.sv
// Operand stack command/response bundle: the master issues op/data each cycle, and the
// slave reports its top-of-stack view and the result of the last op.
interface operand_stack_if #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic [2:0]            op;
   logic [WIDTH-1:0]      data;
   logic [WIDTH-1:0]      tos;
   logic [WIDTH-1:0]      nos;
   logic [DEPTH_LOG2:0]   count;
   logic [1:0]            status;
   logic [1:0]            error;

   modport master (
      output op, data,
      input  tos, nos, count, status, error
   );

   modport slave (
      input  op, data,
      output tos, nos, count, status, error
   );
endinterface

// File: rtl/operand_stack.sv
// Bounded LIFO operand stack with one op per cycle, two write ports for SWAP,
// and a non-sticky per-op error code. Only count and error are reset.
module operand_stack #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input logic            clk,
   input logic            reset,
   operand_stack_if.slave bus
);
   localparam int unsigned Cap  = 2 ** DEPTH_LOG2;
   localparam int unsigned IdxW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
   localparam logic [DEPTH_LOG2:0] CntZero = '0;
   localparam logic [DEPTH_LOG2:0] CntOne  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0] CntTwo  = (DEPTH_LOG2 + 1)'(2);
   localparam logic [DEPTH_LOG2:0] CntCap  = (DEPTH_LOG2 + 1)'(Cap);

   typedef enum logic [2:0] {
      OpNop, OpPush, OpPop, OpReplace, OpDup, OpSwap, OpPop2Push, OpIllegal
   } op_e;

   typedef enum logic [1:0] {ErrNone, ErrUnderflow, ErrOverflow, ErrIllegal} err_e;

   logic [WIDTH-1:0]    mem [Cap];
   logic [DEPTH_LOG2:0] count_q, count_d;
   err_e                error_q, error_d;

   logic [IdxW-1:0]     top_idx, sec_idx, push_idx;
   logic [WIDTH-1:0]    top_val, sec_val;
   logic                is_empty, is_full, has_two;
   op_e                 op;

   logic                wa_en, wb_en;
   logic [IdxW-1:0]     wa_idx, wb_idx;
   logic [WIDTH-1:0]    wa_val, wb_val;

   assign op       = op_e'(bus.op);
   assign top_idx  = IdxW'(count_q - CntOne);
   assign sec_idx  = IdxW'(count_q - CntTwo);
   assign push_idx = IdxW'(count_q);
   assign top_val  = mem[top_idx];
   assign sec_val  = mem[sec_idx];
   assign is_empty = (count_q == CntZero);
   assign is_full  = (count_q == CntCap);
   assign has_two  = (count_q > CntOne);

   // Stale array entries above count are masked so they never reach the outputs.
   assign bus.tos    = is_empty ? '0 : top_val;
   assign bus.nos    = has_two ? sec_val : '0;
   assign bus.count  = count_q;
   assign bus.status = is_full ? 2'd2 : (is_empty ? 2'd1 : 2'd0);
   assign bus.error  = error_q;

   always_comb begin
      count_d = count_q;
      error_d = ErrNone;
      wa_en   = 1'b0;
      wa_idx  = top_idx;
      wa_val  = bus.data;
      wb_en   = 1'b0;
      wb_idx  = sec_idx;
      wb_val  = top_val;
      case (op)
         OpNop: ;
         OpPush: begin
            if (is_full) begin
               error_d = ErrOverflow;
            end else begin
               wa_en   = 1'b1;
               wa_idx  = push_idx;
               count_d = count_q + CntOne;
            end
         end
         OpPop: begin
            if (is_empty) error_d = ErrUnderflow;
            else          count_d = count_q - CntOne;
         end
         OpReplace: begin
            if (is_empty) error_d = ErrUnderflow;
            else          wa_en   = 1'b1;
         end
         OpDup: begin
            // Underflow outranks overflow, so the empty check comes first.
            if (is_empty) begin
               error_d = ErrUnderflow;
            end else if (is_full) begin
               error_d = ErrOverflow;
            end else begin
               wa_en   = 1'b1;
               wa_idx  = push_idx;
               wa_val  = top_val;
               count_d = count_q + CntOne;
            end
         end
         OpSwap: begin
            if (!has_two) begin
               error_d = ErrUnderflow;
            end else begin
               wa_en  = 1'b1;
               wa_val = sec_val;
               wb_en  = 1'b1;
            end
         end
         OpPop2Push: begin
            if (!has_two) begin
               error_d = ErrUnderflow;
            end else begin
               wb_en   = 1'b1;
               wb_val  = bus.data;
               count_d = count_q - CntOne;
            end
         end
         OpIllegal: error_d = ErrIllegal;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= CntZero;
         error_q <= ErrNone;
      end else begin
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wa_en) mem[wa_idx] <= wa_val;
      if (!reset && wb_en) mem[wb_idx] <= wb_val;
   end
endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed vector table, reset corner cases,
// and random ops checked against a queue-based reference model.
module tb_operand_stack;
   localparam int unsigned W   = 8;
   localparam int unsigned DL  = 2;
   localparam int          CAP = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   operand_stack_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();
   operand_stack #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] data;
      logic [7:0] tos;
      logic [7:0] nos;
      logic [2:0] cnt;
      logic [1:0] st;
      logic [1:0] err;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mq[$];
   logic [1:0] merr = 2'd0;

   function automatic vec_t mk(input logic [2:0] o, input logic [7:0] d, input logic [7:0] t,
                               input logic [7:0] n, input logic [2:0] c, input logic [1:0] s,
                               input logic [1:0] e);
      vec_t v;
      v.op = o; v.data = d; v.tos = t; v.nos = n; v.cnt = c; v.st = s; v.err = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] t, input logic [7:0] n,
                        input logic [2:0] c, input logic [1:0] s, input logic [1:0] e);
      n_tests++;
      if (bus.tos !== t || bus.nos !== n || bus.count !== c || bus.status !== s ||
          bus.error !== e) begin
         n_fail++;
         $display("FAIL %s: got tos=%h nos=%h count=%0d status=%0d error=%0d, want tos=%h nos=%h count=%0d status=%0d error=%0d",
                  name, bus.tos, bus.nos, bus.count, bus.status, bus.error, t, n, c, s, e);
      end
   endtask

   // Reference model: the stack is a queue whose back is the top of stack.
   task automatic model_step(input logic [2:0] o, input logic [7:0] d);
      int n = mq.size();
      logic [7:0] tmp;
      case (o)
         3'd0: merr = 2'd0;
         3'd1: if (n == CAP) merr = 2'd2; else begin mq.push_back(d); merr = 2'd0; end
         3'd2: if (n < 1) merr = 2'd1; else begin tmp = mq.pop_back(); merr = 2'd0; end
         3'd3: if (n < 1) merr = 2'd1; else begin mq[n-1] = d; merr = 2'd0; end
         3'd4: if (n < 1) merr = 2'd1;
               else if (n == CAP) merr = 2'd2;
               else begin mq.push_back(mq[n-1]); merr = 2'd0; end
         3'd5: if (n < 2) merr = 2'd1;
               else begin tmp = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = tmp; merr = 2'd0; end
         3'd6: if (n < 2) merr = 2'd1;
               else begin tmp = mq.pop_back(); tmp = mq.pop_back(); mq.push_back(d); merr = 2'd0; end
         default: merr = 2'd3;
      endcase
   endtask

   task automatic check_model(input string name);
      int n = mq.size();
      logic [7:0] t, nx;
      logic [1:0] s;
      t  = (n >= 1) ? mq[n-1] : 8'h00;
      nx = (n >= 2) ? mq[n-2] : 8'h00;
      s  = (n == CAP) ? 2'd2 : ((n == 0) ? 2'd1 : 2'd0);
      check(name, t, nx, 3'(n), s, merr);
   endtask

   task automatic step(input logic [2:0] o, input logic [7:0] d);
      bus.op = o;
      bus.data = d;
      @(posedge clk);
      #1;
      model_step(o, d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   vec_t tbl[$];

   initial begin
      bus.op = 3'd0;
      bus.data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 8'h00, 8'h00, 3'd0, 2'd1, 2'd0);
      reset = 1'b0;

      tbl.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 3'd0, 2'd1, 2'd1));
      tbl.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 2'd1, 2'd0));
      tbl.push_back(mk(3'd1, 8'h11, 8'h11, 8'h00, 3'd1, 2'd0, 2'd0));
      tbl.push_back(mk(3'd1, 8'h22, 8'h22, 8'h11, 3'd2, 2'd0, 2'd0));
      tbl.push_back(mk(3'd1, 8'h33, 8'h33, 8'h22, 3'd3, 2'd0, 2'd0));
      tbl.push_back(mk(3'd1, 8'h44, 8'h44, 8'h33, 3'd4, 2'd2, 2'd0));
      tbl.push_back(mk(3'd1, 8'h55, 8'h44, 8'h33, 3'd4, 2'd2, 2'd2));
      tbl.push_back(mk(3'd4, 8'h00, 8'h44, 8'h33, 3'd4, 2'd2, 2'd2));
      tbl.push_back(mk(3'd2, 8'h00, 8'h33, 8'h22, 3'd3, 2'd0, 2'd0));
      tbl.push_back(mk(3'd2, 8'h00, 8'h22, 8'h11, 3'd2, 2'd0, 2'd0));
      tbl.push_back(mk(3'd5, 8'h00, 8'h11, 8'h22, 3'd2, 2'd0, 2'd0));
      tbl.push_back(mk(3'd4, 8'h00, 8'h11, 8'h11, 3'd3, 2'd0, 2'd0));
      tbl.push_back(mk(3'd6, 8'h99, 8'h99, 8'h22, 3'd2, 2'd0, 2'd0));
      tbl.push_back(mk(3'd2, 8'h00, 8'h22, 8'h00, 3'd1, 2'd0, 2'd0));
      tbl.push_back(mk(3'd3, 8'h07, 8'h07, 8'h00, 3'd1, 2'd0, 2'd0));
      tbl.push_back(mk(3'd5, 8'h00, 8'h07, 8'h00, 3'd1, 2'd0, 2'd1));
      tbl.push_back(mk(3'd6, 8'hEE, 8'h07, 8'h00, 3'd1, 2'd0, 2'd1));
      tbl.push_back(mk(3'd3, 8'h08, 8'h08, 8'h00, 3'd1, 2'd0, 2'd0));
      tbl.push_back(mk(3'd7, 8'hFF, 8'h08, 8'h00, 3'd1, 2'd0, 2'd3));
      tbl.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 3'd0, 2'd1, 2'd0));
      tbl.push_back(mk(3'd3, 8'h5A, 8'h00, 8'h00, 3'd0, 2'd1, 2'd1));
      tbl.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, 3'd0, 2'd1, 2'd1));
      tbl.push_back(mk(3'd1, 8'h01, 8'h01, 8'h00, 3'd1, 2'd0, 2'd0));
      tbl.push_back(mk(3'd1, 8'h02, 8'h02, 8'h01, 3'd2, 2'd0, 2'd0));
      tbl.push_back(mk(3'd1, 8'h03, 8'h03, 8'h02, 3'd3, 2'd0, 2'd0));
      tbl.push_back(mk(3'd2, 8'h00, 8'h02, 8'h01, 3'd2, 2'd0, 2'd0));
      tbl.push_back(mk(3'd2, 8'h00, 8'h01, 8'h00, 3'd1, 2'd0, 2'd0));
      tbl.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 3'd0, 2'd1, 2'd0));

      foreach (tbl[i]) begin
         step(tbl[i].op, tbl[i].data);
         check($sformatf("vec%0d_op%0d", i, tbl[i].op), tbl[i].tos, tbl[i].nos, tbl[i].cnt,
               tbl[i].st, tbl[i].err);
      end

      // Asynchronous reset between edges with three entries on the stack.
      step(3'd1, 8'hC1);
      step(3'd1, 8'hC2);
      step(3'd1, 8'hC3);
      check_model("pre_async_reset");
      bus.op = 3'd1;
      bus.data = 8'hBB;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_mid_cycle", 8'h00, 8'h00, 3'd0, 2'd1, 2'd0);
      @(posedge clk);
      #1;
      check("push_ignored_in_reset", 8'h00, 8'h00, 3'd0, 2'd1, 2'd0);
      reset = 1'b0;
      mq.delete();
      merr = 2'd0;
      step(3'd1, 8'hA5);
      check("push_after_reset", 8'hA5, 8'h00, 3'd1, 2'd0, 2'd0);

      // Random ops against the queue model, with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] o;
         int r = int'($urandom_range(0, 99));
         if (r < 30)      o = 3'd1;
         else if (r < 45) o = 3'd2;
         else             o = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
            mq.delete();
            merr = 2'd0;
            check_model($sformatf("rand_reset%0d", i));
         end
         step(o, 8'($urandom));
         check_model($sformatf("rand%0d_op%0d", i, o));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 WIDTH, 32, entry width in bits (>=1).
REQ-002 DEPTH_LOG2, 4, log2 of capacity; CAP = 2**DEPTH_LOG2 entries (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op  input  3  operation code, sampled every rising edge.
REQ-006 data  input  WIDTH  operand for PUSH, REPLACE, POP2PUSH; ignored otherwise.
REQ-007 tos  output  WIDTH  top-of-stack entry; 0 when count==0.
REQ-008 nos  output  WIDTH  next-on-stack entry; 0 when count<2.
REQ-009 count  output  DEPTH_LOG2+1  number of valid entries, 0..CAP.
REQ-010 status  output  2  NONE=0, EMPTY=1 (count==0), FULL=2 (count==CAP).
REQ-011 error  output  2  NONE=0, UNDERFLOW=1, OVERFLOW=2, ILLEGAL=3; result of the last sampled op.

Function
REQ-012 Op encoding SHALL be: NOP=0, PUSH=1, POP=2, REPLACE=3, DUP=4, SWAP=5, POP2PUSH=6, 7 reserved.
REQ-013 All outputs SHALL be registered or derived from registered state only; an op sampled at edge N is reflected in tos/nos/count/status/error immediately after edge N (latency 1 edge, one op per cycle).
REQ-014 PUSH: new entry = data; count+1; previous tos becomes nos.
REQ-015 POP: remove top; count-1; nos becomes tos.
REQ-016 REPLACE: top entry = data; count unchanged.
REQ-017 DUP: push a copy of tos; count+1.
REQ-018 SWAP: exchange top two entries; count unchanged.
REQ-019 POP2PUSH: remove top two entries and push data; count-1 (binary-op result write-back).
REQ-020 NOP SHALL change no entry and SHALL set error=NONE.
REQ-021 Minimum count preconditions: POP, REPLACE, DUP need count>=1; SWAP, POP2PUSH need count>=2; violation SHALL set error=UNDERFLOW.
REQ-022 PUSH or DUP with count==CAP SHALL set error=OVERFLOW (DUP at count==0 reports UNDERFLOW, underflow check takes priority).
REQ-023 op=7 SHALL set error=ILLEGAL.
REQ-024 Any op setting error!=NONE SHALL leave count and all entries unchanged.
REQ-025 Any successful op SHALL set error=NONE; error is not sticky.
REQ-026 status SHALL be EMPTY when count==0, FULL when count==CAP, else NONE; with CAP==1 FULL takes precedence only when count==1.
REQ-027 Storage SHALL be a CAP-entry array indexed by a stack pointer; no wrap-around: pointer never leaves 0..CAP.
REQ-028 Entries above count SHALL NOT be observable on tos/nos.

Reset
REQ-029 While reset is high, regardless of clk: count=0, tos=0, nos=0, status=EMPTY, error=NONE; op is ignored.
REQ-030 Reset asserted mid-sequence SHALL discard all entries; the first op after release SHALL see an empty stack.
REQ-031 Array contents need not be cleared by reset; they SHALL be unobservable per REQ-028.

Verification (WIDTH=8, DEPTH_LOG2=2, CAP=4)
REQ-032 Reset, then POP -> error=UNDERFLOW, count=0, status=EMPTY; then NOP -> error=NONE.
REQ-033 PUSH 0x11,0x22,0x33,0x44 -> after 4th: tos=0x44, nos=0x33, count=4, status=FULL; PUSH 0x55 -> error=OVERFLOW, tos=0x44; DUP -> error=OVERFLOW, count=4.
REQ-034 From 0x11,0x22 (tos 0x22): SWAP -> tos=0x11, nos=0x22; DUP -> tos=0x11, nos=0x11, count=3; POP2PUSH data=0x99 -> tos=0x99, nos=0x22, count=2.
REQ-035 count=1 (tos 0x07): SWAP -> UNDERFLOW, tos=0x07, nos=0; POP2PUSH -> UNDERFLOW; REPLACE data=0x08 -> tos=0x08, error=NONE; op=7 -> error=ILLEGAL, tos=0x08.
REQ-036 Pop stack fully after 3 pushes -> count steps 2,1,0, status NONE,NONE,EMPTY, tos=0 at end.
REQ-037 Assert reset asynchronously between edges with count=3 -> count=0, status=EMPTY before the next edge; after release PUSH 0xA5 -> tos=0xA5, nos=0, count=1.
